// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, buffers the returned word for IF/ID and applies branch and exception redirects.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  input  logic        ID_BranchTaken,
  input  logic [31:0] ID_BranchTarget,
  input  logic        EXC_Redirect,
  input  logic [31:0] EXC_Vector,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ready,
  input  logic        IM_RValid,
  input  logic [31:0] IM_RData,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall,
  output logic        IF_Flush
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_DISCARD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] buf_pcadd4;
  logic        bds_pend;
  logic        redir_pend;
  logic [31:0] redir_target;

  logic        consume;
  logic        badv;
  logic        accept;
  logic        load_buf;
  logic        adv_pc;
  logic [31:0] next_pc;
  logic [31:0] branch_target;
  logic [31:0] exc_target;

  assign branch_target = ID_BranchTarget & ~32'h3;
  assign exc_target    = EXC_Vector & ~32'h3;
  assign consume       = buf_valid & ~ID_Stall;
  assign badv          = ID_IsBranch & ~ID_Stall;

  // A branch that left ID while its delay slot was still in flight leaves its
  // redirect pending until that delay slot is consumed.
  always_comb begin
    next_pc = buf_pc + 32'd4;
    if (ID_IsBranch && ID_BranchTaken)
      next_pc = branch_target;
    else if (bds_pend && redir_pend)
      next_pc = redir_target;
  end

  always_comb begin
    IM_Req     = ~EXC_Redirect & ((state == S_IDLE) | ((state == S_VALID) & consume));
    IM_Addr    = (state == S_VALID) ? next_pc : fetch_pc;
    accept     = IM_Req & IM_Ready;
    state_next = state;
    load_buf   = 1'b0;
    adv_pc     = 1'b0;
    if (EXC_Redirect) begin
      if ((state == S_WAIT) || ((state == S_DISCARD) && !IM_RValid))
        state_next = S_DISCARD;
      else
        state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (accept) state_next = S_WAIT;
        S_WAIT: begin
          if (IM_RValid) begin
            load_buf   = 1'b1;
            state_next = S_VALID;
          end
        end
        S_VALID: begin
          if (consume) begin
            adv_pc     = 1'b1;
            state_next = accept ? S_WAIT : S_IDLE;
          end
        end
        S_DISCARD: if (IM_RValid) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      buf_valid    <= 1'b0;
      buf_instr    <= '0;
      buf_pc       <= '0;
      buf_pcadd4   <= '0;
      bds_pend     <= 1'b0;
      redir_pend   <= 1'b0;
      redir_target <= '0;
    end else if (EXC_Redirect) begin
      fetch_pc   <= exc_target;
      buf_valid  <= 1'b0;
      bds_pend   <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      if (badv && !buf_valid) begin
        bds_pend     <= 1'b1;
        redir_pend   <= ID_BranchTaken;
        redir_target <= branch_target;
      end
      if (load_buf) begin
        buf_instr  <= IM_RData;
        buf_pc     <= fetch_pc;
        buf_pcadd4 <= fetch_pc + 32'd4;
        buf_valid  <= 1'b1;
      end
      if (adv_pc) begin
        fetch_pc   <= next_pc;
        buf_valid  <= 1'b0;
        bds_pend   <= 1'b0;
        redir_pend <= 1'b0;
      end
    end
  end

  assign IF_Instruction = buf_valid ? buf_instr : 32'h0;
  assign IF_PC          = buf_pc;
  assign IF_PCAdd4      = buf_pcadd4;
  assign IF_IsBDS       = buf_valid & (ID_IsBranch | bds_pend);
  assign IF_Stall       = ~buf_valid;
  assign IF_Flush       = EXC_Redirect;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a small latency-programmable instruction memory plus
// hand-computed expectations walked cycle by cycle.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Stall;
  logic        ID_IsBranch;
  logic        ID_BranchTaken;
  logic [31:0] ID_BranchTarget;
  logic        EXC_Redirect;
  logic [31:0] EXC_Vector;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic        IM_RValid;
  logic [31:0] IM_RData;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCAdd4;
  logic        IF_IsBDS;
  logic        IF_Stall;
  logic        IF_Flush;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  logic [3:0]  cnt   = 4'd0;
  logic [31:0] word  = 32'h0;

  ifetch dut (
    .clk(clk), .rst(rst),
    .ID_Stall(ID_Stall), .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .ID_BranchTarget(ID_BranchTarget), .EXC_Redirect(EXC_Redirect), .EXC_Vector(EXC_Vector),
    .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ready(IM_Ready), .IM_RValid(IM_RValid),
    .IM_RData(IM_RData), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC),
    .IF_PCAdd4(IF_PCAdd4), .IF_IsBDS(IF_IsBDS), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory answers `lat` cycles after acceptance; it ignores rst so that an
  // in-flight response still shows up after the DUT has been reset.
  always @(posedge clk) begin
    if (IM_Req && IM_Ready) begin
      cnt  <= 4'(lat);
      word <= code(IM_Addr);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
  assign IM_RValid = (cnt == 4'd1);
  assign IM_RData  = word;

  task automatic applyStimulus(input logic stall, input logic br, input logic tk,
                               input logic [31:0] tgt, input logic ex,
                               input logic [31:0] vec, input logic rdy, input int l);
    @(negedge clk);
    ID_Stall        = stall;
    ID_IsBranch     = br;
    ID_BranchTaken  = tk;
    ID_BranchTarget = tgt;
    EXC_Redirect    = ex;
    EXC_Vector      = vec;
    IM_Ready        = rdy;
    lat             = l;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ID_Stall = 0; ID_IsBranch = 0; ID_BranchTaken = 0; ID_BranchTarget = 0;
    EXC_Redirect = 0; EXC_Vector = 0; IM_Ready = 0;
    #2;
    checkOutput("rst_req", 32'(IM_Req), 32'd1);
    checkOutput("rst_addr", IM_Addr, 32'hBFC0_0000);
    checkOutput("rst_stall", 32'(IF_Stall), 32'd1);
    checkOutput("rst_instr", IF_Instruction, 32'h0);
    checkOutput("rst_pc", IF_PC, 32'h0);
    checkOutput("rst_pcadd4", IF_PCAdd4, 32'h0);
    checkOutput("rst_bds", 32'(IF_IsBDS), 32'd0);

    // Sequential fetch from reset
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1); rst = 1'b0; #1;
    checkOutput("c0_req", 32'(IM_Req), 32'd1);
    checkOutput("c0_addr", IM_Addr, 32'hBFC0_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("c1_stall", 32'(IF_Stall), 32'd1);
    checkOutput("c1_req", 32'(IM_Req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("c2_stall", 32'(IF_Stall), 32'd0);
    checkOutput("c2_pc", IF_PC, 32'hBFC0_0000);
    checkOutput("c2_pcadd4", IF_PCAdd4, 32'hBFC0_0004);
    checkOutput("c2_instr", IF_Instruction, code(32'hBFC0_0000));
    checkOutput("c2_addr", IM_Addr, 32'hBFC0_0004);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("c3_stall", 32'(IF_Stall), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("c4_stall", 32'(IF_Stall), 32'd0);
    checkOutput("c4_pc", IF_PC, 32'hBFC0_0004);
    checkOutput("c4_addr", IM_Addr, 32'hBFC0_0008);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    // Downstream stall for three cycles while VALID
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("stl_stall", 32'(IF_Stall), 32'd0);
      checkOutput("stl_req", 32'(IM_Req), 32'd0);
      checkOutput("stl_pc", IF_PC, 32'hBFC0_0008);
      checkOutput("stl_instr", IF_Instruction, code(32'hBFC0_0008));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("stl_rel_req", 32'(IM_Req), 32'd1);
    checkOutput("stl_rel_addr", IM_Addr, 32'hBFC0_000C);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    // Redirect from VALID to 0x20, then taken branch with delay slot buffered
    applyStimulus(0, 0, 0, 0, 1, 32'h20, 1, 1);
    checkOutput("ex20_pc", IF_PC, 32'hBFC0_000C);
    checkOutput("ex20_flush", 32'(IF_Flush), 32'd1);
    checkOutput("ex20_req", 32'(IM_Req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("f20_req", 32'(IM_Req), 32'd1);
    checkOutput("f20_addr", IM_Addr, 32'h20);
    checkOutput("f20_instr", IF_Instruction, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 1, 32'h103, 0, 0, 1, 1);
    checkOutput("br_pc", IF_PC, 32'h20);
    checkOutput("br_bds", 32'(IF_IsBDS), 32'd1);
    checkOutput("br_req", 32'(IM_Req), 32'd1);
    checkOutput("br_addr", IM_Addr, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h24, 1, 1);
    checkOutput("tgt_pc", IF_PC, 32'h100);
    checkOutput("tgt_bds", 32'(IF_IsBDS), 32'd0);

    // Taken branch advancing while the delay slot (0x24) is still in flight
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("f24_addr", IM_Addr, 32'h24);
    applyStimulus(0, 1, 1, 32'h200, 0, 0, 1, 1);
    checkOutput("wbr_stall", 32'(IF_Stall), 32'd1);
    checkOutput("wbr_bds", 32'(IF_IsBDS), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("ds_pc", IF_PC, 32'h24);
    checkOutput("ds_bds", 32'(IF_IsBDS), 32'd1);
    checkOutput("ds_req", 32'(IM_Req), 32'd1);
    checkOutput("ds_addr", IM_Addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("t200_pc", IF_PC, 32'h200);
    checkOutput("t200_bds", 32'(IF_IsBDS), 32'd0);
    checkOutput("t200_addr", IM_Addr, 32'h204);

    // Exception during WAIT; the late response must be discarded
    applyStimulus(0, 0, 0, 0, 1, 32'h8000_0183, 1, 3);
    checkOutput("exw_flush", 32'(IF_Flush), 32'd1);
    checkOutput("exw_req", 32'(IM_Req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("dis1_req", 32'(IM_Req), 32'd0);
    checkOutput("dis1_stall", 32'(IF_Stall), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("dis2_req", 32'(IM_Req), 32'd0);
    checkOutput("dis2_instr", IF_Instruction, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("vec_req", 32'(IM_Req), 32'd1);
    checkOutput("vec_addr", IM_Addr, 32'h8000_0180);
    checkOutput("vec_stall", 32'(IF_Stall), 32'd1);
    checkOutput("vec_instr", IF_Instruction, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    // Backpressure: Ready low for four cycles
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("bp_pc", IF_PC, 32'h8000_0180);
    checkOutput("bp_instr", IF_Instruction, code(32'h8000_0180));
    checkOutput("bp_addr0", IM_Addr, 32'h8000_0184);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("bp_req", 32'(IM_Req), 32'd1);
      checkOutput("bp_addr", IM_Addr, 32'h8000_0184);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("bp_acc_addr", IM_Addr, 32'h8000_0184);

    // Asynchronous reset while WAIT
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("prerst_pc", IF_PC, 32'h8000_0180);
    checkOutput("prerst_req", 32'(IM_Req), 32'd0);
    #2; rst = 1'b1; #1;
    checkOutput("arst_req", 32'(IM_Req), 32'd1);
    checkOutput("arst_addr", IM_Addr, 32'hBFC0_0000);
    checkOutput("arst_pc", IF_PC, 32'h0);
    checkOutput("arst_pcadd4", IF_PCAdd4, 32'h0);
    checkOutput("arst_stall", 32'(IF_Stall), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); rst = 1'b0; #1;
    checkOutput("rel_addr", IM_Addr, 32'hBFC0_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("stale_stall", 32'(IF_Stall), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("stale_after", 32'(IF_Stall), 32'd1);
    checkOutput("stale_instr", IF_Instruction, 32'h0);
    checkOutput("refetch_addr", IM_Addr, 32'hBFC0_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

    // Wrap-around at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1);
    checkOutput("rf_pc", IF_PC, 32'hBFC0_0000);
    checkOutput("rf_instr", IF_Instruction, code(32'hBFC0_0000));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("wrap_addr0", IM_Addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("wrap_pc", IF_PC, 32'hFFFF_FFFC);
    checkOutput("wrap_pcadd4", IF_PCAdd4, 32'h0);
    checkOutput("wrap_addr", IM_Addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage, sitting directly upstream of the IF/ID pipeline register. It owns the PC and issues one outstanding request at a time to instruction memory over a request/response handshake. It buffers the returned word and presents `IF_Instruction`, `IF_PC`, `IF_PCAdd4`, `IF_IsBDS`, `IF_Stall` and `IF_Flush` to IF/ID. It also resolves delayed-branch redirects from ID and exception redirects from later stages.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset; bits [1:0] must be 0.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; asynchronous and active-high.
- `ID_Stall`, input, 1: IF/ID is holding; the IF output is not consumed this cycle.
- `ID_IsBranch`, input, 1: the instruction in ID is a branch or jump, taken or not.
- `ID_BranchTaken`, input, 1: qualifies `ID_BranchTarget`; meaningful only with `ID_IsBranch`.
- `ID_BranchTarget`, input, 32: target address; bits [1:0] are ignored (forced 0).
- `EXC_Redirect`, input, 1: single-cycle exception/flush request.
- `EXC_Vector`, input, 32: redirect address; bits [1:0] are ignored (forced 0).
- `IM_Req`, output, 1: fetch request valid.
- `IM_Addr`, output, 32: fetch address, word aligned.
- `IM_Ready`, input, 1: memory accepts the request on `IM_Req & IM_Ready`.
- `IM_RValid`, input, 1: read data valid.
- `IM_RData`, input, 32: instruction word.
- `IF_Instruction`, output, 32: buffered instruction; 0 when the buffer is empty.
- `IF_PC`, output, 32: PC of the buffered instruction.
- `IF_PCAdd4`, output, 32: `IF_PC + 4`, registered, with 32-bit wrap.
- `IF_IsBDS`, output, 1: the buffered instruction is a branch delay slot.
- `IF_Stall`, output, 1: no valid instruction is available (`~buf_valid`).
- `IF_Flush`, output, 1: equals `EXC_Redirect`, combinational.

## Operation
- **Registers:**
  - `fetch_pc`
  - `state` ∈ {IDLE, WAIT, VALID, DISCARD}
  - `buf_valid`, `buf_instr`, `buf_pc`, `buf_pcadd4`
  - `bds_pend`, `redir_pend`, `redir_target`
- **Consume:** `consume = buf_valid & ~ID_Stall`.
- **Branch advance:** `badv = ID_IsBranch & ~ID_Stall`.
- **Delay-slot flag:** `IF_IsBDS = buf_valid & (ID_IsBranch | bds_pend)`.
- **Next PC on consume,** evaluated in priority order:
  1. If `ID_IsBranch` is high and `ID_BranchTaken` is high, use `ID_BranchTarget`.
  2. Otherwise, if `bds_pend` and `redir_pend` are both high, use `redir_target`.
  3. Otherwise use `buf_pc + 4`.
- **Branch advance while the buffer is empty** (`badv & ~buf_valid`):
  - Set `bds_pend = 1`, `redir_pend = ID_BranchTaken`, `redir_target = ID_BranchTarget`.
  - These flags are cleared on the next consume.
- **Request generation:**
  - `IM_Req = ~EXC_Redirect & ((state==IDLE) | (state==VALID & consume))`.
  - `IM_Addr` is `fetch_pc` in IDLE and `next_pc` in VALID.
- **State transitions:**
  - **IDLE:** accept → WAIT; no accept → stay in IDLE.
  - **WAIT:** on `IM_RValid`:
    - load `buf_instr = IM_RData`, `buf_pc = fetch_pc`, `buf_pcadd4 = fetch_pc + 4`;
    - set `buf_valid = 1`;
    - go to VALID.
  - **VALID with consume:** `fetch_pc <= next_pc`, `buf_valid <= 0`; then accept → WAIT, otherwise → IDLE.
  - **VALID without consume:** hold all registers; `IM_Req = 0`.
  - **DISCARD:** on `IM_RValid`, drop the data and go to IDLE.
- **`EXC_Redirect` (highest priority, any state):**
  - `fetch_pc <= EXC_Vector`; clear `buf_valid`, `bds_pend` and `redir_pend`.
  - WAIT, or DISCARD without `IM_RValid` this cycle → DISCARD.
  - All other cases → IDLE.
  - `IM_RValid` arriving in the same cycle as `EXC_Redirect` is dropped.
- **Protocol rules:**
  - `IM_Req` may be retracted (on redirect or stall) without acceptance; memory acts only on `Req & Ready`.
  - `IM_RValid` outside WAIT/DISCARD is ignored.

## Timing
- **Reset values (asynchronous):**
  - state = IDLE, `fetch_pc = RESET_PC`;
  - all buffer and pending registers 0;
  - `IF_Instruction = 0`, `IF_PC = 0`, `IF_PCAdd4 = 0`, `IF_IsBDS = 0`, `IF_Stall = 1`;
  - `IM_Req` is 1 in the first cycle after reset release, with `IM_Addr = RESET_PC`. `IF_Flush` follows its input.
- **Reset mid-transaction:** any in-flight response is ignored, because the block is in IDLE after reset.
- **Latency:** request accepted in cycle 0 with `IM_RValid` in cycle 1 → `IF_Stall = 0` in cycle 2.
- **Steady throughput:** 1 instruction per 2 cycles with zero-wait memory.
- **Output stability:** while `ID_Stall` is high, all `IF_*` outputs stay stable and no new request is issued.
- **Delay slot:** the instruction after a branch is always fetched sequentially, and the branch target is fetched immediately after it.
- **Wrap-around:** the PC wraps from `32'hFFFF_FFFC` to `32'h0000_0000`; `IF_PCAdd4 = 0` at that point.

## Test plan
1. **Reset and sequential fetch.** Release reset; memory has Ready=1 and 1-cycle RValid.
   - `IM_Addr` sequence: BFC00000, BFC00004, BFC00008.
   - `IF_Stall` low on cycles 2, 4, 6.
   - `IF_PCAdd4 = IF_PC + 4`.
2. **Downstream stall.** Hold `ID_Stall = 1` for 3 cycles while VALID.
   - Outputs are frozen and `IM_Req = 0` throughout.
   - After release, the next `IM_Addr` is `buf_pc + 4`.
3. **Taken branch, delay slot already buffered.** `ID_IsBranch = 1`, `ID_BranchTaken = 1`, `ID_BranchTarget = 0x100`, buffer holding PC 0x20.
   - `IF_IsBDS = 1` that cycle.
   - `IM_Addr = 0x100` in the same cycle.
4. **Taken branch, buffer empty.** Branch advances while WAIT for PC 0x24, target 0x200.
   - The 0x24 instruction is presented with `IF_IsBDS = 1`.
   - The next fetch is 0x200, and `bds_pend` is clear afterwards.
5. **Exception during WAIT.** `EXC_Redirect` with vector 0x80000180.
   - `IF_Flush = 1` and `IM_Req = 0` that cycle.
   - The stale `IM_RValid` is discarded, then `IM_Addr = 0x80000180` is requested.
   - No stale word ever reaches `IF_Instruction`.
6. **Backpressure and async reset.**
   - `IM_Ready = 0` for 4 cycles: `IM_Addr` stays stable.
   - Asserting `rst` while in WAIT: outputs go to their reset values immediately, without a clock edge.
